axi_lite_register_slice: RTL and testbench
==========================================

Name: axi_lite_register_slice

Overview:
- Timing-closure stage placed directly upstream of the opaque AXI4-Lite bridge.
- Its master port drives the bridge's slave port.
- Registers all five AXI4-Lite channels (AW, W, B, AR, R) with independent two-entry skid buffers.
- Breaks every combinational valid, ready and payload path while keeping full throughput.

Parameters:
C_AXI_ADDR_WIDTH, 32, address width (A)
C_AXI_DATA_WIDTH, 32, data width (D); must be a multiple of 8

Ports:
aclk  in  1  system clock; all logic on the rising edge
areset  in  1  synchronous, active-high reset
s_axi_awaddr  in  A  slave write address
s_axi_awprot  in  3  slave write protection
s_axi_awvalid  in  1  slave AW valid
s_axi_awready  out  1  slave AW ready
s_axi_wdata  in  D  slave write data
s_axi_wstrb  in  D/8  slave write strobes
s_axi_wvalid  in  1  slave W valid
s_axi_wready  out  1  slave W ready
s_axi_bresp  out  2  slave write response
s_axi_bvalid  out  1  slave B valid
s_axi_bready  in  1  slave B ready
s_axi_araddr  in  A  slave read address
s_axi_arprot  in  3  slave read protection
s_axi_arvalid  in  1  slave AR valid
s_axi_arready  out  1  slave AR ready
s_axi_rdata  out  D  slave read data
s_axi_rresp  out  2  slave read response
s_axi_rvalid  out  1  slave R valid
s_axi_rready  in  1  slave R ready
m_axi_awaddr/awprot/awvalid  out  A/3/1  master AW channel
m_axi_awready  in  1  master AW ready
m_axi_wdata/wstrb/wvalid  out  D/D/8/1  master W channel
m_axi_wready  in  1  master W ready
m_axi_bresp/bvalid  in  2/1  master B channel
m_axi_bready  out  1  master B ready
m_axi_araddr/arprot/arvalid  out  A/3/1  master AR channel
m_axi_arready  in  1  master AR ready
m_axi_rdata/rresp/rvalid  in  D/2/1  master R channel
m_axi_rready  out  1  master R ready

Behaviour:
- One identical skid-buffer instance per channel.
  - Forward channels (AW, W, AR): source is s_, sink is m_.
  - Reverse channels (B, R): source is m_, sink is s_.
- Per-channel state:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main register holds a beat, out_valid=1, in_ready=1.
  - FULL: main and skid registers both hold beats, out_valid=1, in_ready=0.
- Transitions (acc = in_valid&in_ready, pop = out_valid&out_ready):
  - EMPTY: acc -> ONE.
  - ONE: acc&!pop -> FULL; pop&!acc -> EMPTY; acc&pop -> ONE, with the new beat loaded into main.
  - FULL: pop -> ONE, with skid moved to main. No accept is possible in FULL.
- Every output is driven from a flop. in_ready is a registered copy of "skid empty". No combinational path exists from any input to any output.
- Latency: an accepted beat appears at the output on the next cycle; zero bubbles when out_ready is held high.
- Sustained rate: 1 beat/cycle per channel.
- Beats leave in acceptance order; no beat is dropped or duplicated.
- Payload and out_valid stay stable while out_valid=1 and out_ready=0 (AXI rule).
- Channels are fully independent: no AW/W pairing and no read/write ordering imposed.
- Reset (areset=1 sampled at a clock edge), on that edge:
  - all *valid outputs = 0;
  - all *ready outputs = 0;
  - payload outputs = 0;
  - both buffers emptied.
- Ready outputs rise to 1 on the first edge after areset is sampled low.
- Asserting areset mid-transfer discards buffered beats. There is no recovery of in-flight transactions; upstream must also be reset.
- Payload register widths equal the port widths exactly. No arithmetic is performed.

Test Plan:
1. Reset release:
   - Hold areset for 3 cycles -> all valids 0, all readies 0 during reset.
   - Cycle after release -> s_axi_awready, wready, arready, m_axi_bready, m_axi_rready all = 1.
2. Streaming:
   - AW beats addr 0x100..0x10F, one per cycle, m_axi_awready=1 -> m_axi_awaddr shows the same sequence delayed 1 cycle, no gaps.
3. Back-pressure:
   - Drop m_axi_wready for 4 cycles during a wdata stream -> one extra beat is captured in skid, s_axi_wready=0 the next cycle.
   - m_axi_wdata holds steady.
   - On release, all beats delivered in order with wstrb intact.
4. Reverse channels:
   - m_axi_rvalid with rdata 0xDEADBEEF, rresp=2'b10, s_axi_rready toggling 1/0 -> s_axi_rdata=0xDEADBEEF and s_axi_rresp=2'b10 appear once each, only when s_axi_rready=1.
   - Same check for B with bresp=2'b11.
5. Mid-operation reset:
   - Fill AR to FULL (arready=0), assert areset for 1 cycle -> m_axi_arvalid=0 next cycle.
   - The stale araddr is never presented after reset.
6. Channel independence:
   - Stall AR sink while streaming AW/W/B -> AW, W and B throughput is unaffected, with 1 beat/cycle.

Source files
------------

// File: rtl/axi_lite_register_slice.sv
// AXI4-Lite register slice: every channel passes through its own two-entry skid buffer.
// One cycle of latency per channel, full throughput, and every output comes straight from a flop.
module axi_lite_register_slice #(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                    s_axi_awprot,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                    s_axi_arprot,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int AW_W = C_AXI_ADDR_WIDTH + 3;
  localparam int W_W  = C_AXI_DATA_WIDTH + C_AXI_DATA_WIDTH / 8;
  localparam int R_W  = C_AXI_DATA_WIDTH + 2;

  axi_lite_register_slice_skid #(.W(AW_W)) u_aw (
    .clk       (aclk),
    .rst       (areset),
    .in_data   ({s_axi_awaddr, s_axi_awprot}),
    .in_valid  (s_axi_awvalid),
    .in_ready  (s_axi_awready),
    .out_data  ({m_axi_awaddr, m_axi_awprot}),
    .out_valid (m_axi_awvalid),
    .out_ready (m_axi_awready)
  );

  axi_lite_register_slice_skid #(.W(W_W)) u_w (
    .clk       (aclk),
    .rst       (areset),
    .in_data   ({s_axi_wdata, s_axi_wstrb}),
    .in_valid  (s_axi_wvalid),
    .in_ready  (s_axi_wready),
    .out_data  ({m_axi_wdata, m_axi_wstrb}),
    .out_valid (m_axi_wvalid),
    .out_ready (m_axi_wready)
  );

  axi_lite_register_slice_skid #(.W(2)) u_b (
    .clk       (aclk),
    .rst       (areset),
    .in_data   (m_axi_bresp),
    .in_valid  (m_axi_bvalid),
    .in_ready  (m_axi_bready),
    .out_data  (s_axi_bresp),
    .out_valid (s_axi_bvalid),
    .out_ready (s_axi_bready)
  );

  axi_lite_register_slice_skid #(.W(AW_W)) u_ar (
    .clk       (aclk),
    .rst       (areset),
    .in_data   ({s_axi_araddr, s_axi_arprot}),
    .in_valid  (s_axi_arvalid),
    .in_ready  (s_axi_arready),
    .out_data  ({m_axi_araddr, m_axi_arprot}),
    .out_valid (m_axi_arvalid),
    .out_ready (m_axi_arready)
  );

  axi_lite_register_slice_skid #(.W(R_W)) u_r (
    .clk       (aclk),
    .rst       (areset),
    .in_data   ({m_axi_rdata, m_axi_rresp}),
    .in_valid  (m_axi_rvalid),
    .in_ready  (m_axi_rready),
    .out_data  ({s_axi_rdata, s_axi_rresp}),
    .out_valid (s_axi_rvalid),
    .out_ready (s_axi_rready)
  );

endmodule

// Two-entry skid buffer: a main register drives the output, and a skid register catches the
// single beat that lands while the sink stalls. Ready is registered, so no input reaches an output.
module axi_lite_register_slice_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] skid_data;
  logic         skid_valid;
  logic         acc;
  logic         pop;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      in_ready <= 1'b1;
      if (skid_valid) begin
        // FULL: in_ready is low, so the only possible event is a pop.
        if (pop) begin
          out_data   <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          in_ready <= 1'b0;
        end
      end else if (out_valid) begin
        if (acc && pop) begin
          out_data <= in_data;
        end else if (acc) begin
          skid_data  <= in_data;
          skid_valid <= 1'b1;
          in_ready   <= 1'b0;
        end else if (pop) begin
          out_valid <= 1'b0;
        end
      end else if (acc) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_register_slice.sv
// Directed bench for axi_lite_register_slice with a per-channel scoreboard of expected beats.
module tb_axi_lite_register_slice;
  localparam int A = 32;
  localparam int D = 32;

  logic aclk = 1'b0;
  logic areset;
  logic [A-1:0] s_axi_awaddr;  logic [2:0] s_axi_awprot;  logic s_axi_awvalid, s_axi_awready;
  logic [D-1:0] s_axi_wdata;   logic [D/8-1:0] s_axi_wstrb; logic s_axi_wvalid, s_axi_wready;
  logic [1:0]   s_axi_bresp;   logic s_axi_bvalid, s_axi_bready;
  logic [A-1:0] s_axi_araddr;  logic [2:0] s_axi_arprot;  logic s_axi_arvalid, s_axi_arready;
  logic [D-1:0] s_axi_rdata;   logic [1:0] s_axi_rresp;   logic s_axi_rvalid, s_axi_rready;
  logic [A-1:0] m_axi_awaddr;  logic [2:0] m_axi_awprot;  logic m_axi_awvalid, m_axi_awready;
  logic [D-1:0] m_axi_wdata;   logic [D/8-1:0] m_axi_wstrb; logic m_axi_wvalid, m_axi_wready;
  logic [1:0]   m_axi_bresp;   logic m_axi_bvalid, m_axi_bready;
  logic [A-1:0] m_axi_araddr;  logic [2:0] m_axi_arprot;  logic m_axi_arvalid, m_axi_arready;
  logic [D-1:0] m_axi_rdata;   logic [1:0] m_axi_rresp;   logic m_axi_rvalid, m_axi_rready;

  axi_lite_register_slice #(.C_AXI_ADDR_WIDTH(A), .C_AXI_DATA_WIDTH(D)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  logic [A+2:0]       aw_q[$];
  logic [D+D/8-1:0]   w_q[$];
  logic [1:0]         b_q[$];
  logic [A+2:0]       ar_q[$];
  logic [D+1:0]       r_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Sink-side monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge aclk) begin
    if (areset === 1'b0) begin
      if (m_axi_awvalid && m_axi_awready) begin
        chk("aw_q_nonempty", 64'(aw_q.size() != 0), 64'd1);
        if (aw_q.size() != 0) chk("aw_beat", 64'({m_axi_awaddr, m_axi_awprot}), 64'(aw_q.pop_front()));
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("w_q_nonempty", 64'(w_q.size() != 0), 64'd1);
        if (w_q.size() != 0) chk("w_beat", 64'({m_axi_wdata, m_axi_wstrb}), 64'(w_q.pop_front()));
      end
      if (s_axi_bvalid && s_axi_bready) begin
        chk("b_q_nonempty", 64'(b_q.size() != 0), 64'd1);
        if (b_q.size() != 0) chk("b_beat", 64'(s_axi_bresp), 64'(b_q.pop_front()));
      end
      if (m_axi_arvalid && m_axi_arready) begin
        chk("ar_q_nonempty", 64'(ar_q.size() != 0), 64'd1);
        if (ar_q.size() != 0) chk("ar_beat", 64'({m_axi_araddr, m_axi_arprot}), 64'(ar_q.pop_front()));
      end
      if (s_axi_rvalid && s_axi_rready) begin
        chk("r_q_nonempty", 64'(r_q.size() != 0), 64'd1);
        if (r_q.size() != 0) chk("r_beat", 64'({s_axi_rdata, s_axi_rresp}), 64'(r_q.pop_front()));
      end
    end
  end

  initial begin
    int k;
    int c;
    logic rdy;
    areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rvalid = 1'b0;

    // Reset release
    repeat (3) begin
      tick();
      chk("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, s_axi_bvalid, m_axi_arvalid, s_axi_rvalid}), 64'd0);
      chk("rst_readies", 64'({s_axi_awready, s_axi_wready, m_axi_bready, s_axi_arready, m_axi_rready}), 64'd0);
      chk("rst_payload", 64'(m_axi_awaddr | m_axi_wdata | m_axi_araddr | s_axi_rdata), 64'd0);
    end
    areset = 1'b0;
    tick();
    chk("rel_readies", 64'({s_axi_awready, s_axi_wready, m_axi_bready, s_axi_arready, m_axi_rready}), 64'h1f);

    // AW streaming, one cycle of latency, no gaps
    m_axi_awready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_axi_awaddr = 32'h100 + 32'(i); s_axi_awprot = 3'(i); s_axi_awvalid = 1'b1;
      chk("aw_in_ready", 64'(s_axi_awready), 64'd1);
      aw_q.push_back({s_axi_awaddr, s_axi_awprot});
      tick();
      chk("aw_lat_valid", 64'(m_axi_awvalid), 64'd1);
      chk("aw_lat_addr", 64'(m_axi_awaddr), 64'h100 + 64'(i));
    end
    s_axi_awvalid = 1'b0;
    tick();
    chk("aw_idle", 64'(m_axi_awvalid), 64'd0);

    // W back-pressure: sink stalls for iterations 3..6
    k = 0; c = 0;
    while (k < 12 && c < 100) begin
      s_axi_wdata = 32'hA000_0000 + 32'(k); s_axi_wstrb = 4'(k); s_axi_wvalid = 1'b1;
      m_axi_wready = !(c >= 3 && c <= 6);
      rdy = s_axi_wready;
      if (c >= 4 && c <= 7) chk("w_skid_full", 64'(rdy), 64'd0);
      if (c >= 3 && c <= 7) chk("w_hold_data", 64'({m_axi_wvalid, m_axi_wdata}), 64'h1_A000_0002);
      if (rdy) w_q.push_back({s_axi_wdata, s_axi_wstrb});
      tick();
      c++;
      if (rdy) k++;
    end
    chk("w_all_sent", 64'(k), 64'd12);
    s_axi_wvalid = 1'b0; m_axi_wready = 1'b1;
    repeat (2) tick();
    chk("w_drained", 64'(w_q.size()), 64'd0);

    // R reverse channel with toggling sink ready
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hDEAD_BEEF; m_axi_rresp = 2'b10;
    chk("r_in_ready", 64'(m_axi_rready), 64'd1);
    r_q.push_back({m_axi_rdata, m_axi_rresp});
    tick();
    m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    chk("r_presented", 64'({s_axi_rvalid, s_axi_rdata, s_axi_rresp}), {30'd0, 1'b1, 32'hDEAD_BEEF, 2'b10});
    for (int i = 0; i < 8; i++) begin
      s_axi_rready = (i % 2 == 1);
      tick();
    end
    s_axi_rready = 1'b0;
    chk("r_drained", 64'(r_q.size()), 64'd0);
    chk("r_idle", 64'(s_axi_rvalid), 64'd0);

    // B reverse channel with toggling sink ready
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b11;
    chk("b_in_ready", 64'(m_axi_bready), 64'd1);
    b_q.push_back(m_axi_bresp);
    tick();
    m_axi_bvalid = 1'b0; m_axi_bresp = '0;
    chk("b_presented", 64'({s_axi_bvalid, s_axi_bresp}), 64'h7);
    for (int i = 0; i < 8; i++) begin
      s_axi_bready = (i % 2 == 1);
      tick();
    end
    chk("b_drained", 64'(b_q.size()), 64'd0);
    chk("b_idle", 64'(s_axi_bvalid), 64'd0);

    // Mid-operation reset with AR full
    m_axi_arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_axi_araddr = 32'h200 + 32'(i); s_axi_arprot = 3'd5; s_axi_arvalid = 1'b1;
      chk("ar_fill_ready", 64'(s_axi_arready), 64'd1);
      tick();
    end
    s_axi_arvalid = 1'b0;
    chk("ar_full", 64'({s_axi_arready, m_axi_arvalid, m_axi_araddr}), {31'd0, 1'b0, 1'b1, 32'h200});
    areset = 1'b1;
    tick();
    chk("ar_rst_valid", 64'({m_axi_arvalid, s_axi_arready}), 64'd0);
    chk("ar_rst_addr", 64'(m_axi_araddr), 64'd0);
    areset = 1'b0; m_axi_arready = 1'b1;
    tick();
    chk("ar_rel_ready", 64'(s_axi_arready), 64'd1);
    repeat (3) begin
      tick();
      chk("ar_no_stale", 64'(m_axi_arvalid), 64'd0);
    end

    // Channel independence: AR stalled while AW, W and B stream
    m_axi_arready = 1'b0; s_axi_bready = 1'b1; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_axi_awaddr = 32'h300 + 32'(i); s_axi_awprot = 3'(i); s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'hB000_0000 + 32'(i); s_axi_wstrb = 4'hF ^ 4'(i); s_axi_wvalid = 1'b1;
      m_axi_bresp = 2'(i); m_axi_bvalid = 1'b1;
      s_axi_araddr = 32'h400 + 32'(i); s_axi_arvalid = (i < 2);
      chk("ind_ready", 64'({s_axi_awready, s_axi_wready, m_axi_bready}), 64'h7);
      if (i < 2) begin
        chk("ind_ar_ready", 64'(s_axi_arready), 64'd1);
        ar_q.push_back({s_axi_araddr, s_axi_arprot});
      end else begin
        chk("ind_ar_stalled", 64'(s_axi_arready), 64'd0);
      end
      aw_q.push_back({s_axi_awaddr, s_axi_awprot});
      w_q.push_back({s_axi_wdata, s_axi_wstrb});
      b_q.push_back(m_axi_bresp);
      tick();
      chk("ind_out_valid", 64'({m_axi_awvalid, m_axi_wvalid, s_axi_bvalid}), 64'h7);
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; m_axi_bvalid = 1'b0; s_axi_arvalid = 1'b0;
    tick();
    m_axi_arready = 1'b1;
    repeat (4) tick();
    chk("end_queues", 64'(aw_q.size() + w_q.size() + b_q.size() + ar_q.size() + r_q.size()), 64'd0);
    chk("end_valids", 64'({m_axi_awvalid, m_axi_wvalid, s_axi_bvalid, m_axi_arvalid, s_axi_rvalid}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
